// File: rtl/ecc_enc_dec_engine.sv
// ecc_enc_dec_engine: fixed-latency extended-Hamming (SECDED) encode/decode/full-channel engine
module ecc_enc_dec_engine #(
    parameter int AMBA_WORD  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] NOISE,
    output logic [AMBA_WORD-1:0] data_out,
    output logic                 operation_done,
    output logic [1:0]           num_of_errors,
    output logic                 busy
);
    localparam int SW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, CAPTURE, ENC, CHAN, DEC, DONE} state_t;

    state_t                state;
    logic [1:0]            op;
    logic [1:0]            wid;
    logic [1:0]            err;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] noise;
    logic [DATA_WIDTH-1:0] cw;
    logic [DATA_WIDTH-1:0] msk;
    logic [SW-1:0]         s;
    logic                  par;
    int                    n;
    logic                  unused;

    assign unused = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};

    // XOR of the positions of all set bits below n (bit 0 has position 0 and never contributes)
    function automatic logic [SW-1:0] syn(input logic [DATA_WIDTH-1:0] c, input int len);
        logic [SW-1:0] r;
        r = '0;
        for (int p = 1; p < DATA_WIDTH; p++)
            if (p < len && c[p]) r = r ^ SW'(p);
        return r;
    endfunction

    // Data bits fill non-power-of-two positions in ascending order
    function automatic logic [DATA_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] c, input int len);
        logic [DATA_WIDTH-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int p = 1; p < DATA_WIDTH; p++)
            if (p < len && (p & (p - 1)) != 0) begin
                d[j] = c[p];
                j = j + 1;
            end
        return d;
    endfunction

    // Parity bit 2^i equals bit i of the data-only syndrome, which makes the full syndrome zero
    function automatic logic [DATA_WIDTH-1:0] enc(input logic [DATA_WIDTH-1:0] d, input int len);
        logic [DATA_WIDTH-1:0] c;
        logic [SW-1:0] ps;
        int j;
        c = '0;
        j = 0;
        for (int p = 1; p < DATA_WIDTH; p++)
            if (p < len && (p & (p - 1)) != 0) begin
                c[p] = d[j];
                j = j + 1;
            end
        ps = syn(c, len);
        for (int i = 0; i < SW; i++) c[1 << i] = ps[i];
        c[0] = ^c;
        return c;
    endfunction

    // Codeword length, mask and decode syndrome/parity derived from the snapshotted width
    always_comb begin
        n   = wid == 2'd0 ? 8 : wid == 2'd1 ? 16 : DATA_WIDTH;
        msk = n >= DATA_WIDTH ? '1 : (DATA_WIDTH'(1) << n) - DATA_WIDTH'(1);
        s   = syn(cw, n);
        par = ^(cw & msk);
    end

    // Operation sequencer: one state per pipeline step, outputs registered in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            op             <= 2'd0;
            wid            <= 2'd0;
            err            <= 2'd0;
            data           <= '0;
            noise          <= '0;
            cw             <= '0;
            data_out       <= '0;
            num_of_errors  <= 2'd0;
            operation_done <= 1'b0;
            busy           <= 1'b0;
        end else begin
            operation_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        op    <= CTRL[1:0];
                        wid   <= CODEWORD_WIDTH[1:0];
                        data  <= DATA_IN[DATA_WIDTH-1:0];
                        noise <= NOISE[DATA_WIDTH-1:0];
                        busy  <= 1'b1;
                        state <= CAPTURE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CAPTURE: state <= ENC;
                ENC: begin
                    cw    <= op == 2'b01 ? data & msk : enc(data, n);
                    state <= CHAN;
                end
                CHAN: begin
                    if (op == 2'b10) cw <= cw ^ (noise & msk);
                    state <= DEC;
                end
                DEC: begin
                    if (op == 2'b01 || op == 2'b10) begin
                        err <= par ? 2'd1 : (|s) ? 2'd2 : 2'd0;
                        if (par) cw[s] <= ~cw[s];
                    end
                    state <= DONE;
                end
                DONE: begin
                    data_out       <= op == 2'b00 ? AMBA_WORD'(cw) : op == 2'b11 ? '0 : AMBA_WORD'(ext(cw, n));
                    num_of_errors  <= (op == 2'b01 || op == 2'b10) ? err : 2'd0;
                    operation_done <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_enc_dec_engine.sv
// tb_ecc_enc_dec_engine: randomized and directed checks of the SECDED engine against a positional model
module tb_ecc_enc_dec_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ctrl = '0;
    logic [31:0] din = '0;
    logic [31:0] cwid = '0;
    logic [31:0] noise = '0;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    ecc_enc_dec_engine #(.AMBA_WORD(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .CTRL(ctrl), .DATA_IN(din),
        .CODEWORD_WIDTH(cwid), .NOISE(noise), .data_out(data_out),
        .operation_done(operation_done), .num_of_errors(num_of_errors), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int nof(input logic [1:0] w);
        return w == 2'd0 ? 8 : w == 2'd1 ? 16 : 32;
    endfunction

    function automatic logic [31:0] mmask(input int n);
        return n == 32 ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
    endfunction

    function automatic logic [31:0] m_enc(input logic [31:0] d, input int n);
        logic [31:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < n; pos++)
            if ($countones(pos) > 1) begin
                c[pos] = d[j];
                j++;
            end
        for (int b = 1; b < n; b = b * 2) begin
            int cnt;
            cnt = 0;
            for (int pos = 1; pos < n; pos++)
                if ((pos & b) != 0 && c[pos]) cnt++;
            c[b] = (cnt % 2) == 1;
        end
        c[0] = ($countones(c) % 2) == 1;
        return c;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] c, input int n);
        logic [31:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < n; pos++)
            if ($countones(pos) > 1) begin
                d[j] = c[pos];
                j++;
            end
        return d;
    endfunction

    task automatic m_ref(input logic [1:0] op, input logic [1:0] w, input logic [31:0] d,
                         input logic [31:0] nz, output logic [31:0] ed, output logic [1:0] ee);
        int n;
        int s;
        logic [31:0] c;
        n = nof(w);
        c = op == 2'd1 ? d & mmask(n) : m_enc(d, n);
        if (op == 2'd2) c = c ^ (nz & mmask(n));
        ed = '0;
        ee = 2'd0;
        if (op == 2'd0) ed = c;
        else if (op != 2'd3) begin
            s = 0;
            for (int pos = 1; pos < n; pos++) if (c[pos]) s = s ^ pos;
            if ($countones(c) % 2 == 1) begin
                c[s] = ~c[s];
                ee = 2'd1;
            end else ee = s != 0 ? 2'd2 : 2'd0;
            ed = m_ext(c, n);
        end
    endtask

    // Called at posedge+1; leaves one idle cycle, strobes start, scrambles operands, waits for done
    task automatic run_op(input logic [1:0] op, input logic [1:0] w, input logic [31:0] d,
                          input logic [31:0] nz, output logic [31:0] dout, output logic [1:0] ne,
                          output int lat);
        @(posedge clk); #1;
        ctrl = {30'($urandom), op};
        cwid = {30'($urandom), w};
        din = d;
        noise = nz;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ctrl = $urandom;
        din = $urandom;
        noise = $urandom;
        cwid = $urandom;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!operation_done && lat < 20);
        dout = data_out;
        ne = num_of_errors;
    endtask

    task automatic test_reset;
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", data_out); end
        checks++; if (num_of_errors !== 2'd0) begin errors++; $display("FAIL rst_errs got %0d exp 0", num_of_errors); end
        checks++; if (operation_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", operation_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || operation_done !== 1'b0) begin errors++; $display("FAIL post_rst_idle got busy=%b done=%b exp 0 0", busy, operation_done); end
    endtask

    task automatic test_encode;
        logic [31:0] d;
        logic [1:0] e;
        int l;
        run_op(2'd0, 2'd0, 32'hB, 32'h0, d, e, l);
        checks++; if (l !== 5) begin errors++; $display("FAIL enc8_latency got %0d exp 5", l); end
        checks++; if (d !== 32'hAA) begin errors++; $display("FAIL enc8_data got %h exp %h", d, 32'hAA); end
        checks++; if (e !== 2'd0) begin errors++; $display("FAIL enc8_errs got %0d exp 0", e); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enc8_busy_in_done got %b exp 1", busy); end
    endtask

    task automatic test_full;
        logic [31:0] d;
        logic [1:0] e;
        int l;
        run_op(2'd2, 2'd0, 32'hB, 32'h04, d, e, l);
        checks++; if (d !== 32'hB || e !== 2'd1) begin errors++; $display("FAIL full_single got %h/%0d exp %h/1", d, e, 32'hB); end
        run_op(2'd2, 2'd0, 32'hB, 32'h06, d, e, l);
        checks++; if (d !== 32'hB || e !== 2'd2) begin errors++; $display("FAIL full_double got %h/%0d exp %h/2", d, e, 32'hB); end
        run_op(2'd3, 2'd0, 32'hB, 32'h0, d, e, l);
        checks++; if (d !== 32'h0 || e !== 2'd0 || l !== 5) begin errors++; $display("FAIL reserved got %h/%0d lat %0d exp 0/0 lat 5", d, e, l); end
    endtask

    task automatic test_decode;
        logic [31:0] d;
        logic [1:0] e;
        int l;
        run_op(2'd1, 2'd0, 32'hAA, 32'h0, d, e, l);
        checks++; if (d !== 32'hB || e !== 2'd0) begin errors++; $display("FAIL dec_clean got %h/%0d exp %h/0", d, e, 32'hB); end
        run_op(2'd1, 2'd0, 32'hAB, 32'h0, d, e, l);
        checks++; if (d !== 32'hB || e !== 2'd1) begin errors++; $display("FAIL dec_bit0 got %h/%0d exp %h/1", d, e, 32'hB); end
    endtask

    task automatic test_wide;
        logic [31:0] d, cw, ed;
        logic [1:0] e, ee;
        int l;
        m_ref(2'd0, 2'd2, 32'h03FF_FFFF, 32'h0, ed, ee);
        run_op(2'd0, 2'd2, 32'h03FF_FFFF, 32'h0, cw, e, l);
        checks++; if (cw !== ed || e !== 2'd0) begin errors++; $display("FAIL wide_enc got %h/%0d exp %h/0", cw, e, ed); end
        run_op(2'd1, 2'd2, cw, 32'h0, d, e, l);
        checks++; if (d !== 32'h03FF_FFFF || e !== 2'd0) begin errors++; $display("FAIL wide_dec got %h/%0d exp %h/0", d, e, 32'h03FF_FFFF); end
        run_op(2'd2, 2'd2, 32'h03FF_FFFF, 32'h1 << 17, d, e, l);
        checks++; if (d !== 32'h03FF_FFFF || e !== 2'd1) begin errors++; $display("FAIL wide_full got %h/%0d exp %h/1", d, e, 32'h03FF_FFFF); end
    endtask

    task automatic test_random;
        logic [31:0] d, ed, nz;
        logic [1:0] e, ee, op, w;
        int l, n, p1, p2, flips;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            w = 2'($urandom_range(0, 3));
            n = nof(w);
            flips = $urandom_range(0, 2);
            p1 = $urandom_range(0, n - 1);
            p2 = (p1 + 1 + $urandom_range(0, n - 2)) % n;
            nz = (flips > 0 ? 32'h1 << p1 : 32'h0) | (flips > 1 ? 32'h1 << p2 : 32'h0) | ($urandom & ~mmask(n));
            d = $urandom;
            m_ref(op, w, d, nz, ed, ee);
            run_op(op, w, d, nz, d, e, l);
            checks++;
            if (d !== ed || e !== ee || l !== 5) begin
                errors++;
                $display("FAIL rand_%0d op%0d w%0d got %h/%0d lat %0d exp %h/%0d lat 5", i, op, w, d, e, l, ed, ee);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ed;
        logic [1:0] ee;
        int dones, l;
        m_ref(2'd0, 2'd1, 32'h5A5, 32'h0, ed, ee);
        @(posedge clk); #1;
        ctrl = 32'h0;
        cwid = 32'h1;
        din = 32'h5A5;
        start = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise got %b exp 1", busy); end
        ctrl = 32'h2;
        din = 32'h123;
        dones = 0;
        l = 0;
        while (!operation_done && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        checks++; if (l !== 5 || data_out !== ed) begin errors++; $display("FAIL b2b_first got %h lat %0d exp %h lat 5", data_out, l, ed); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall got %b exp 0", busy); end
        repeat (10) begin
            @(posedge clk); #1;
            if (operation_done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL b2b_extra_done got %0d exp 0", dones); end
        checks++; if (data_out !== ed || num_of_errors !== 2'd0) begin errors++; $display("FAIL b2b_hold got %h/%0d exp %h/0", data_out, num_of_errors, ed); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic [1:0] e;
        int l, dones;
        run_op(2'd2, 2'd0, 32'hB, 32'h04, d, e, l);
        checks++; if (d !== 32'hB || e !== 2'd1) begin errors++; $display("FAIL pre_rst_op got %h/%0d exp %h/1", d, e, 32'hB); end
        @(posedge clk); #1;
        ctrl = 32'h2;
        cwid = 32'h0;
        din = 32'h5;
        noise = 32'h0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++; if (data_out !== 32'h0 || num_of_errors !== 2'd0) begin errors++; $display("FAIL mid_rst_outputs got %h/%0d exp 0/0", data_out, num_of_errors); end
        checks++; if (busy !== 1'b0 || operation_done !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got busy=%b done=%b exp 0 0", busy, operation_done); end
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (operation_done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL mid_rst_done got %0d exp 0", dones); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_encode;
        test_full;
        test_decode;
        test_wide;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
